seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter: the source end of the bit-serial sequence-detection path. On a start request it emits a fixed PAT_W-bit pattern (default 1101), MSB first, one bit per clock, repeated a programmable number of times with a programmable idle gap between repetitions. Its `out`/`valid` pair drives the serial input of the team's Moore sequence detectors, both in the datapath and in loopback self-test.

## Interface
Parameters:
- PAT_W, 4, pattern width in bits (2..16)
- PATTERN, 4'b1101, transmitted pattern, sent MSB first
- CNT_W, 8, width of repetition counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- reps  input  CNT_W  number of pattern repetitions, latched on accepted start; 0 treated as 1
- gap  input  4  idle cycles between repetitions, latched on accepted start
- abort  input  1  synchronous cancel, any state
- out  output  1  serial bit (registered)
- valid  output  1  high while `out` carries a pattern or parity bit
- busy  output  1  high from accepted start to last transmitted bit inclusive
- done  output  1  one-cycle pulse after the final bit of the final repetition

## Operation
- Reset (reset=0, asynchronous): state IDLE; out=0, valid=0, busy=0, done=0; counters cleared.
- All outputs are registered and change only on rising clk, except on reset.
- States: IDLE, SEND, PAR (only with the parity option), GAP, DONE.
- IDLE: out=0, valid=0. If start=1 and abort=0, latch reps (0→1) and gap, load bit index PAT_W-1, go to SEND. Drive out=PATTERN[PAT_W-1], valid=1, and busy=1 on that same edge.
- SEND: each cycle drive out=PATTERN[idx], valid=1, and decrement idx. After bit 0:
  - go to PAR if enabled;
  - else, if the remaining-reps count is greater than 1: go to GAP when gap>0, or reload idx and stay in SEND when gap=0, which makes the repetitions back-to-back;
  - else go to DONE.
- PAR: one cycle with out=parity bit, valid=1; the same exit rules as the end of SEND apply.
- GAP: out=0, valid=0, busy=1 for exactly `gap` cycles, then SEND with idx reloaded.
- DONE: done=1, busy=0, valid=0, out=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored; latched reps/gap are unaffected.
- abort=1: on the next edge go to IDLE with out=0, valid=0, busy=0, done=0. No done pulse. Abort has priority over start.
- Repetition counter decrements at the last bit of each repetition. Arithmetic is unsigned with no wrap: max reps = 2^CNT_W−1.

## Timing
- Start accepted at edge k: first bit is on `out` from edge k (visible in cycle k+1). Latency is 1 cycle.
- Bits per repetition: B = PAT_W (+1 with parity).
- Total busy cycles = R·B + (R−1)·G, where R = effective reps and G = gap.
- done pulses in the cycle immediately after the final busy cycle. Earliest next accepted start is the cycle after done.
- valid never asserts during GAP, IDLE or DONE.

## Configuration
- Macro SEQ_TX_PARITY_EN.
- Defined: after each pattern, one extra bit equal to the even-parity bit of PATTERN (XOR of all pattern bits) is sent with valid=1. B = PAT_W+1.
- Undefined: no PAR state, and B = PAT_W.
- Default 1101 with the option defined: each repetition is 1,1,0,1,1.

## Test plan
- Reset, then start with reps=1, gap=0: out=1,1,0,1 with valid=1 for 4 cycles starting 1 cycle after start. done=1 in cycle 5, busy=0 in that cycle.
- reps=3, gap=2: stream 1101 00 1101 00 1101. valid is low for the 2 gap cycles each time, busy is high for 16 cycles, and done is a single pulse afterwards.
- reps=0, gap=5: exactly one pattern is sent, no GAP state is entered, and done follows the 4th bit.
- start pulsed while busy with reps=7: ignored, and the original count completes. abort in the 2nd bit of repetition 2: next cycle valid=0, busy=0, no done pulse, and a new start is accepted the cycle after.
- reset driven low mid-pattern, between clock edges: out, valid, busy and done go to 0 immediately. After release, IDLE waits for start.
- Loopback of out into the 1101 Moore detector with reps=2, gap=0 (parity option off): stream 11011101 yields exactly two detector output pulses. With reps=2, gap=1, it also yields two pulses.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeated with idle gaps.
// Optional trailing even-parity bit per repetition when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic [3:0]       gap,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
`ifdef SEQ_TX_PARITY_EN
        , S_PAR = 3'd4
`endif
    } state_t;

`ifdef SEQ_TX_PARITY_EN
    function automatic logic f_even_parity(input logic [PAT_W-1:0] v);
        return ^v;
    endfunction
`endif

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_reps_left, w_reps_nxt;
    logic [3:0]       r_gap, w_gap_nxt;
    logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic             r_out, w_out_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_rep_end;

    // Next-state and next-output logic; r_state is the state whose outputs are currently visible.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_reps_nxt    = r_reps_left;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_out_nxt     = 1'b0;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_rep_end     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_reps_nxt  = (reps == '0) ? CNT_W'(1) : reps;
                    w_gap_nxt   = gap;
                    w_idx_nxt   = IDX_MSB;
                    w_state_nxt = S_SEND;
                    w_out_nxt   = PATTERN[PAT_W-1];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (r_idx != '0) begin
                    w_idx_nxt   = r_idx - IDX_W'(1);
                    w_out_nxt   = PATTERN[r_idx - IDX_W'(1)];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    w_state_nxt = S_PAR;
                    w_out_nxt   = f_even_parity(PATTERN);
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
`else
                    w_rep_end   = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                w_rep_end = 1'b1;
            end
`endif
            S_GAP: begin
                w_busy_nxt = 1'b1;
                if (r_gap_cnt == 4'd1) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = IDX_MSB;
                    w_out_nxt   = PATTERN[PAT_W-1];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared end-of-repetition decision after the last pattern (or parity) bit.
        if (w_rep_end) begin
            w_reps_nxt = r_reps_left - CNT_W'(1);
            if (r_reps_left > CNT_W'(1)) begin
                w_busy_nxt = 1'b1;
                if (r_gap != 4'd0) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = r_gap;
                end else begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = IDX_MSB;
                    w_out_nxt   = PATTERN[PAT_W-1];
                    w_valid_nxt = 1'b1;
                end
            end else begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
        end else begin
            w_rep_end = 1'b0;
        end

        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_idx_nxt     = '0;
            w_gap_cnt_nxt = 4'd0;
            w_out_nxt     = 1'b0;
            w_valid_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_reps_left <= '0;
            r_gap       <= 4'd0;
            r_gap_cnt   <= 4'd0;
            r_out       <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_reps_left <= w_reps_nxt;
            r_gap       <= w_gap_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_out       <= w_out_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: per-cycle expected {out,valid,busy,done} queued at stimulus,
// popped by a monitor whenever the DUT is active; includes a 1101 loopback detector.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       abort;
    logic       dut_out, valid, busy, done;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sh = 4'b0000;
    int         det_cnt = 0;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .clk   (clk),
        .reset (reset_n),
        .start (start),
        .reps  (reps),
        .gap   (gap),
        .abort (abort),
        .out   (dut_out),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // '1'/'0' = valid pattern bit, 'g' = gap cycle, 'D' = done cycle
    task automatic push_stream(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "1":     exp_q.push_back(4'b1110);
                "0":     exp_q.push_back(4'b0110);
                "g":     exp_q.push_back(4'b0010);
                "D":     exp_q.push_back(4'b0001);
                default: exp_q.push_back(4'b1111);
            endcase
        end
    endtask

    task automatic drive_start(input logic [7:0] r, input logic [3:0] g);
        start = 1'b1;
        reps  = r;
        gap   = g;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || done) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d expected cycles left, busy=%0b", name, exp_q.size(), busy);
            exp_q.delete();
        end
        @(posedge clk); #1;
        check({name, "_idle_after"}, {30'd0, busy, valid}, 32'd0);
    endtask

    // Monitor: scoreboard pop on every active cycle, plus loopback 1101 detector on valid bits.
    always @(negedge clk) begin
        if (valid) begin
            sh = {sh[2:0], dut_out};
            if (sh == 4'b1101) det_cnt++;
        end
        if (reset_n && (valid || busy || done)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got out/valid/busy/done=%b expected idle at %0t",
                         {dut_out, valid, busy, done}, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({dut_out, valid, busy, done} !== e) begin
                    n_fail++;
                    $display("FAIL stream: got out/valid/busy/done=%b expected %b at %0t",
                             {dut_out, valid, busy, done}, e, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        reps    = 8'd0;
        gap     = 4'd0;
        abort   = 1'b0;
        #3;
        check("reset_state", {28'd0, dut_out, valid, busy, done}, 32'd0);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;

        // reps=1 gap=0, then a start during the done cycle must be ignored
        push_stream("1101D");
        drive_start(8'd1, 4'd0);
        check("t1_first_bit", {29'd0, dut_out, valid, busy}, 32'b111);
        repeat (4) begin @(posedge clk); #1; end
        check("t1_done_cycle", {29'd0, done, busy, valid}, 32'b100);
        start = 1'b1;
        reps  = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_start_in_done", {30'd0, busy, valid}, 32'd0);
        wait_idle("t1");

        push_stream("1101gg1101gg1101D");
        drive_start(8'd3, 4'd2);
        wait_idle("t2_reps3_gap2");

        push_stream("1101D");
        drive_start(8'd0, 4'd5);
        wait_idle("t3_reps0");

        // start while busy is ignored
        push_stream("1101g1101D");
        drive_start(8'd2, 4'd1);
        @(posedge clk); #1;
        start = 1'b1;
        reps  = 8'd7;
        gap   = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t4_start_busy");

        // abort during the 2nd bit of repetition 2, restart right after
        push_stream("110111");
        drive_start(8'd7, 4'd0);
        repeat (5) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {29'd0, valid, busy, done}, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);
        push_stream("1101D");
        drive_start(8'd1, 4'd0);
        wait_idle("t5_after_abort");

        // asynchronous reset mid-pattern
        push_stream("1101");
        drive_start(8'd3, 4'd0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {28'd0, dut_out, valid, busy, done}, 32'd0);
        exp_q.delete();
        #10 reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_reset_idle", {30'd0, busy, valid}, 32'd0);
        end

        // loopback into a 1101 detector
        sh = 4'b0000;
        det_cnt = 0;
        push_stream("11011101D");
        drive_start(8'd2, 4'd0);
        wait_idle("loop_gap0");
        check("loop_gap0_pulses", det_cnt, 32'd2);

        sh = 4'b0000;
        det_cnt = 0;
        push_stream("1101g1101D");
        drive_start(8'd2, 4'd1);
        wait_idle("loop_gap1");
        check("loop_gap1_pulses", det_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
